// File: rtl/dffre_bank_ctrl_if.sv
// Write-port bundle shared by the requesters and the bank controller.
//   i_Req   : per-requester write request, held until granted
//   i_Addr  : packed write addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_D     : packed write data, requester k at [k*DATA_W +: DATA_W]
//   o_Grant : one-hot combinational grant back to the requesters
// master = requester side, slave = controller side.
interface dffre_bank_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        i_Req;
  logic [NUM_REQ*ADDR_W-1:0] i_Addr;
  logic [NUM_REQ*DATA_W-1:0] i_D;
  logic [NUM_REQ-1:0]        o_Grant;

  modport master (output i_Req, output i_Addr, output i_D, input o_Grant);
  modport slave  (input i_Req, input i_Addr, input i_D, output o_Grant);
endinterface

// File: rtl/dffre_bank_ctrl.sv
// Round-robin write-port controller for a bank of enable-gated resettable
// registers, with a sequenced one-entry-per-cycle bank clear and a
// registered read port.
//   clk        : rising-edge clock
//   i_Reset_n  : asynchronous active-low reset
//   wr         : write bus (request/address/data in, grant out)
//   i_Clear    : start a full bank clear (ignored while clearing)
//   o_Busy     : high while the clear sequence runs
//   i_Rd_Addr  : read address
//   o_Rd_Data  : read data, one cycle after the address
//   o_Wr_Count : saturating count of committed requester writes
module dffre_bank_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               i_Reset_n,
  dffre_bank_ctrl_if.slave   wr,
  input  logic               i_Clear,
  output logic               o_Busy,
  input  logic [ADDR_W-1:0]  i_Rd_Addr,
  output logic [DATA_W-1:0]  o_Rd_Data,
  output logic [15:0]        o_Wr_Count
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]  LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state_r, next_state_s;
  logic [PTR_W-1:0]    ptr_r;
  logic [ADDR_W-1:0]   clr_idx_r;
  logic                busy_r;
  logic [15:0]         wr_count_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic [DATA_W-1:0]   bank_r [DEPTH];

  logic [NUM_REQ-1:0]  grant_s;
  logic [PTR_W-1:0]    cand_s;
  logic [PTR_W-1:0]    win_s;
  logic                found_s;
  logic                commit_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic                wr_in_range_s;
  logic                rd_in_range_s;

  // Round-robin search starting just after the last winner, ending at it.
  always_comb begin
    grant_s = '0;
    cand_s  = ptr_r;
    win_s   = ptr_r;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_s == LAST_REQ) begin
        cand_s = '0;
      end else begin
        cand_s = cand_s + 1'b1;
      end
      if (!found_s && wr.i_Req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    // Clear request and reset both suppress the grant in the same cycle.
    if (i_Reset_n && (state_r == IDLE) && !i_Clear && found_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign wr.o_Grant = grant_s;
  assign commit_s   = |grant_s;

  // Select the winning requester's address and data slices.
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_s == PTR_W'(k)) begin
        wr_addr_s = wr.i_Addr[k*ADDR_W +: ADDR_W];
        wr_data_s = wr.i_D[k*DATA_W +: DATA_W];
      end else begin
        wr_addr_s = wr_addr_s;
      end
    end
  end

  assign wr_in_range_s = (int'(wr_addr_s) < DEPTH);
  assign rd_in_range_s = (int'(i_Rd_Addr) < DEPTH);

  // Next-state logic: the clear runs until the last entry has been zeroed.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_Clear) begin
          next_state_s = CLEAR;
        end else begin
          next_state_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_idx_r == LAST_IDX) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = CLEAR;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Control state: FSM, clear index, busy flag, RR pointer, write counter.
  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r    <= IDLE;
      clr_idx_r  <= '0;
      busy_r     <= 1'b0;
      ptr_r      <= LAST_REQ;
      wr_count_r <= 16'h0000;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == CLEAR);
      if (state_r == CLEAR) begin
        clr_idx_r <= clr_idx_r + 1'b1;
      end else begin
        clr_idx_r <= '0;
      end
      if (commit_s) begin
        ptr_r <= win_s;
      end else begin
        ptr_r <= ptr_r;
      end
      // Out-of-range addresses still count as committed writes.
      if (commit_s && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'h0001;
      end else begin
        wr_count_r <= wr_count_r;
      end
    end
  end

  // Register bank: one enable per entry, driven by clear sequencing or grant.
  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        bank_r[e] <= '0;
      end
    end else if (state_r == CLEAR) begin
      bank_r[clr_idx_r] <= '0;
    end else if (commit_s && wr_in_range_s) begin
      bank_r[wr_addr_s] <= wr_data_s;
    end else begin
      bank_r[0] <= bank_r[0];
    end
  end

  // Registered read port; sees the pre-edge bank contents (read-before-write).
  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rd_data_r <= '0;
    end else if (rd_in_range_s) begin
      rd_data_r <= bank_r[i_Rd_Addr];
    end else begin
      rd_data_r <= '0;
    end
  end

  assign o_Busy     = busy_r;
  assign o_Rd_Data  = rd_data_r;
  assign o_Wr_Count = wr_count_r;

endmodule

// File: tb/tb_dffre_bank_ctrl.sv
// Self-checking bench for dffre_bank_ctrl: a behavioural model of the bank,
// arbitration and clear sequence checked every cycle, plus directed tests
// with literal expectations.
module tb_dffre_bank_ctrl;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_Clear = 1'b0;
  logic          o_Busy;
  logic [AW-1:0] i_Rd_Addr = '0;
  logic [DW-1:0] o_Rd_Data;
  logic [15:0]   o_Wr_Count;
  logic          chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  dffre_bank_ctrl_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  dffre_bank_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .i_Reset_n(rst_n), .wr(bus.slave), .i_Clear(i_Clear),
    .o_Busy(o_Busy), .i_Rd_Addr(i_Rd_Addr), .o_Rd_Data(o_Rd_Data),
    .o_Wr_Count(o_Wr_Count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_bank [DP] = '{default: 8'h00};
  int m_ptr      = NR - 1;
  int m_clr_left = 0;     // entries still to be cleared; 0 means idle
  int m_cnt      = 0;
  logic [DW-1:0] m_rd = 8'h00;

  function automatic int winner();
    for (int s = 1; s <= NR; s++) begin
      int k;
      k = (m_ptr + s) % NR;
      if (bus.i_Req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_grant();
    int w;
    if (!rst_n || m_clr_left != 0 || i_Clear) return '0;
    w = winner();
    if (w < 0) return '0;
    return 4'b0001 << w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DP; e++) m_bank[e] <= 8'h00;
      m_ptr <= NR - 1; m_clr_left <= 0; m_cnt <= 0; m_rd <= 8'h00;
    end else begin
      int w;
      int a;
      w = winner();
      if (m_clr_left > 0) begin
        m_bank[DP - m_clr_left] <= 8'h00;
        m_clr_left <= m_clr_left - 1;
      end else if (i_Clear) begin
        m_clr_left <= DP;
      end else if (w >= 0) begin
        a = int'(bus.i_Addr[w*AW +: AW]);
        if (a < DP) m_bank[a] <= bus.i_D[w*DW +: DW];
        m_ptr <= w;
        if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
      m_rd <= (int'(i_Rd_Addr) < DP) ? m_bank[i_Rd_Addr] : 8'h00;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 32'(bus.o_Grant), 32'(exp_grant()));
      chk("busy", 32'(o_Busy), 32'(m_clr_left != 0));
      chk("rd_data", 32'(o_Rd_Data), 32'(m_rd));
      chk("wr_count", 32'(o_Wr_Count), 32'(m_cnt[15:0]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int k, input logic on, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_Req[k] = on;
    bus.i_Addr[k*AW +: AW] = a;
    bus.i_D[k*DW +: DW] = d;
  endtask

  task automatic write1(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(k, 1'b1, a, d);
    step();
    bus.i_Req[k] = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    i_Rd_Addr = a;
    step();
    chk(name, 32'(o_Rd_Data), 32'(exp));
  endtask

  initial begin
    int gcnt [NR];
    int last;
    int n;
    logic [DW-1:0] ev;
    bus.i_Req = '0; bus.i_Addr = '0; bus.i_D = '0;

    // Reset then idle
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset_grant", 32'(bus.o_Grant), 32'h0);
    chk("reset_busy", 32'(o_Busy), 32'h0);
    chk("reset_count", 32'(o_Wr_Count), 32'h0);
    for (int a = 0; a < DP; a++) read_chk("reset_rd", AW'(a), 8'h00);

    // Round-robin fairness: winner drops out for one cycle after its grant
    for (int k = 0; k < NR; k++) gcnt[k] = 0;
    last = -1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NR; k++)
        set_req(k, (k != last), AW'(k + 4 * gcnt[k]), DW'(8'h10 * (k + 1) + gcnt[k]));
      #1;
      chk("rr_order", 32'(bus.o_Grant), 32'(4'b0001 << (i % NR)));
      last = i % NR;
      gcnt[last]++;
      step();
    end
    bus.i_Req = '0;
    chk("rr_count", 32'(o_Wr_Count), 32'd8);
    for (int e = 0; e < DP; e++) begin
      ev = DW'(8'h10 * ((e % 4) + 1) + e / 4);
      read_chk("rr_entry", AW'(e), ev);
    end

    // Single write and read
    set_req(0, 1'b1, 3'd3, 8'hA5);
    #1 chk("single_grant", 32'(bus.o_Grant), 32'h1);
    step();
    bus.i_Req = '0;
    read_chk("single_rd", 3'd3, 8'hA5);
    chk("single_count", 32'(o_Wr_Count), 32'd9);

    // Out-of-range read returns 0 only when address >= DEPTH (none for 3 bits); range write counted
    // Clear vs pending request
    for (int e = 0; e < DP; e++) write1(0, AW'(e), 8'hFF);
    set_req(2, 1'b1, 3'd0, 8'h77);
    i_Clear = 1'b1;
    #1 chk("clear_grant0", 32'(bus.o_Grant), 32'h0);
    step();
    i_Clear = 1'b0;
    n = 0;
    while (o_Busy && n < 20) begin
      n++;
      step();
    end
    chk("clear_busy_len", 32'(n), 32'd8);
    #1 chk("clear_first_idle_grant", 32'(bus.o_Grant), 32'h4);
    step();
    bus.i_Req = '0;
    chk("clear_count", 32'(o_Wr_Count), 32'd18);
    read_chk("clear_e0", 3'd0, 8'h77);
    for (int e = 1; e < DP; e++) read_chk("clear_entry", AW'(e), 8'h00);

    // Reset mid-clear
    for (int e = 4; e < DP; e++) write1(1, AW'(e), 8'h5A);
    read_chk("pre_rst_e6", 3'd6, 8'h5A);
    i_Clear = 1'b1;
    step();
    i_Clear = 1'b0;
    repeat (4) step();
    chk("midclr_busy", 32'(o_Busy), 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("async_busy", 32'(o_Busy), 32'h0);
    chk("async_grant", 32'(bus.o_Grant), 32'h0);
    step();
    rst_n = 1'b1;
    chk("rst_count", 32'(o_Wr_Count), 32'h0);
    for (int e = 4; e < DP; e++) read_chk("rst_entry", AW'(e), 8'h00);
    chk("rst_idle_busy", 32'(o_Busy), 32'h0);

    // Read-before-write
    write1(0, 3'd5, 8'h11);
    i_Rd_Addr = 3'd5;
    set_req(0, 1'b1, 3'd5, 8'h3C);
    step();
    bus.i_Req = '0;
    chk("rbw_old", 32'(o_Rd_Data), 32'h11);
    step();
    chk("rbw_new", 32'(o_Rd_Data), 32'h3C);

    // Saturation of the write counter
    set_req(0, 1'b1, 3'd1, 8'h42);
    repeat (65540) step();
    chk("sat_count", 32'(o_Wr_Count), 32'hFFFF);
    repeat (2) step();
    bus.i_Req = '0;
    chk("sat_hold", 32'(o_Wr_Count), 32'hFFFF);
    read_chk("sat_e1", 3'd1, 8'h42);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
